tweak_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the instruction decoder.
- Owns the program counter and issues reads to the synchronous instruction ROM (1-cycle read latency).
- Buffers returned words in a small prefetch FIFO and presents them to the decoder over a valid/ready handshake.
- Accepts a redirect (branch/jump target) that flushes all buffered and in-flight fetches.

---
 rtl/tweak_fetch_pkg.sv | 20 ++
 rtl/tweak_fetch_fifo.sv | 68 ++++++
 rtl/tweak_fetch.sv | 109 ++++++++++
 tb/tb_tweak_fetch.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tweak_fetch_pkg.sv
// Shared widths and the fetch entry layout used by the fetch stage,
// the instruction ROM and the decoder.
package tweak_fetch_pkg;

  localparam int TF_ADDR_W   = 4;
  localparam int TF_WORD_W   = 32;
  localparam int TF_DEPTH    = 2;
  localparam int TF_RESET_PC = 0;

  typedef struct packed {
    logic [TF_WORD_W-1:0] word;
    logic [TF_ADDR_W-1:0] pc;
  } fetch_entry_t;

  // Width of an occupancy count able to hold 0..depth.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tweak_fetch_fifo.sv
// Prefetch FIFO: circular storage of {word, pc} entries with push, pop and
// a single-cycle flush that takes priority over both.
module tweak_fetch_fifo
  import tweak_fetch_pkg::*;
#(
  parameter int DEPTH = TF_DEPTH,
  parameter int W     = TF_WORD_W + TF_ADDR_W
) (
  input  logic                     CLK,
  input  logic                     NRES,
  input  logic                     i_push,
  input  logic [W-1:0]             i_din,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_wr;
  logic             w_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_wr = i_push && !i_flush;
  assign w_rd = i_pop && !o_empty && !i_flush;

  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: the head is only looked at while the level is non-zero.
  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LVL_W'(DEPTH));

endmodule

// File: rtl/tweak_fetch.sv
// Instruction fetch stage: owns the PC, issues reads to a 1-cycle ROM,
// buffers returned words and hands them to the decoder over valid/ready.
module tweak_fetch
  import tweak_fetch_pkg::*;
#(
  parameter int          ADDR_W   = TF_ADDR_W,
  parameter int          WORD_W   = TF_WORD_W,
  parameter int          DEPTH    = TF_DEPTH,
  parameter int unsigned RESET_PC = TF_RESET_PC
) (
  input  logic                   CLK,
  input  logic                   NRES,
  output logic                   rom_rd_en,
  output logic [ADDR_W-1:0]      rom_addr,
  input  logic [WORD_W-1:0]      rom_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_addr,
  output logic                   insn_valid,
  input  logic                   insn_ready,
  output logic [WORD_W-1:0]      insn_data,
  output logic [ADDR_W-1:0]      insn_pc,
  output logic [$clog2(DEPTH):0] fifo_level
);

  // Handshake: a word transfers at a posedge where insn_valid && insn_ready;
  // the head (insn_data/insn_pc) is held stable while valid is high and ready low.

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W:0] DEPTH_C = (LVL_W + 1)'(DEPTH);

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_tag;
  logic              r_inflight;
  logic              r_kill;

  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [LVL_W:0]    w_occupancy;
  logic [LVL_W-1:0]  w_level;
  logic              w_full;
  logic              w_empty;
  entry_t            w_din;
  entry_t            w_head;

  assign w_pop = !w_empty && insn_ready;

  // Credits: buffered words plus the one in flight, minus the one leaving now.
  assign w_occupancy = {1'b0, w_level} + (LVL_W + 1)'(r_inflight)
                     - (LVL_W + 1)'(w_pop);
  assign w_issue     = NRES && !redirect_valid && (w_occupancy < DEPTH_C);

  // A word returning during a redirect is dropped by the flush; r_kill
  // guards the return slot that follows the redirect edge.
  assign w_push = r_inflight && !r_kill;
  assign w_din  = '{word: rom_data, pc: r_tag};

  always_ff @(posedge CLK or negedge NRES) begin
    if (!NRES) begin
      r_pc       <= ADDR_W'(RESET_PC);
      r_tag      <= '0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
    end else if (redirect_valid) begin
      r_pc       <= redirect_addr;
      r_inflight <= 1'b0;
      r_kill     <= r_inflight;
    end else begin
      r_inflight <= w_issue;
      r_kill     <= 1'b0;
      if (w_issue) begin
        r_pc  <= r_pc + 1'b1;
        r_tag <= r_pc;
      end
    end
  end

  tweak_fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (WORD_W + ADDR_W)
  ) u_fifo (
    .CLK     (CLK),
    .NRES    (NRES),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_head  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rom_rd_en  = w_issue;
  assign rom_addr   = r_pc;
  assign insn_valid = !w_empty;
  assign insn_data  = w_empty ? '0 : w_head.word;
  assign insn_pc    = w_empty ? '0 : w_head.pc;
  assign fifo_level = w_level;

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_tweak_fetch.sv
// Bench for tweak_fetch: directed table, hand-written corner sequences and
// random traffic against a queue-based reference model.
module tb_tweak_fetch;
  import tweak_fetch_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 2;

  logic        CLK = 1'b0;
  logic        NRES = 1'b0;
  logic        rom_rd_en;
  logic [3:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid = 1'b0;
  logic [3:0]  redirect_addr = '0;
  logic        insn_valid;
  logic        insn_ready = 1'b0;
  logic [31:0] insn_data;
  logic [3:0]  insn_pc;
  logic [1:0]  fifo_level;

  tweak_fetch dut (
    .CLK            (CLK),
    .NRES           (NRES),
    .rom_rd_en      (rom_rd_en),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .insn_valid     (insn_valid),
    .insn_ready     (insn_ready),
    .insn_data      (insn_data),
    .insn_pc        (insn_pc),
    .fifo_level     (fifo_level)
  );

  // clock / ROM
  always #5 CLK = ~CLK;

  logic [31:0] rom [16];
  initial for (int i = 0; i < 16; i++) rom[i] = 32'hF000_0000 + 32'(i);
  always @(posedge CLK) if (rom_rd_en) rom_data <= rom[rom_addr];

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;

  int           m_pc;
  int           m_tag;
  bit           m_inflight;
  fetch_entry_t exp_q[$];

  logic        s_valid, s_rd, s_accept;
  logic [3:0]  s_pc, s_addr;
  logic [31:0] s_data;
  logic [1:0]  s_level;

  typedef struct {
    logic       ready;
    logic       exp_rd;
    logic       exp_valid;
    logic [3:0] exp_pc;
    logic [1:0] exp_level;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_tag = 0;
    m_inflight = 0;
    exp_q.delete();
  endtask

  // One clock cycle: compare against the model at the negedge, advance the
  // model with this cycle's inputs, then move past the posedge.
  task automatic step();
    bit e_valid, e_pop, e_rd;
    int occ;
    @(negedge CLK);
    s_valid  = insn_valid;
    s_rd     = rom_rd_en;
    s_pc     = insn_pc;
    s_addr   = rom_addr;
    s_data   = insn_data;
    s_level  = fifo_level;
    s_accept = insn_valid && insn_ready;

    e_valid = exp_q.size() > 0;
    e_pop   = e_valid && insn_ready;
    occ     = exp_q.size() + int'(m_inflight) - int'(e_pop);
    e_rd    = !redirect_valid && (occ < DEPTH);

    check("model_rd_en", 32'(rom_rd_en), 32'(e_rd));
    check("model_valid", 32'(insn_valid), 32'(e_valid));
    check("model_level", 32'(fifo_level), 32'(exp_q.size()));
    check("level_bound", 32'(fifo_level <= 2'(DEPTH)), 32'd1);
    if (e_valid) begin
      check("model_pc", 32'(insn_pc), 32'(exp_q[0].pc));
      check("model_data", insn_data, exp_q[0].word);
    end
    if (e_rd) check("model_addr", 32'(rom_addr), 32'(m_pc));

    if (redirect_valid) begin
      exp_q.delete();
      m_pc = int'(redirect_addr);
      m_inflight = 0;
    end else begin
      if (e_pop) void'(exp_q.pop_front());
      if (m_inflight) exp_q.push_back(fetch_entry_t'{word: rom[m_tag], pc: AW'(m_tag)});
      if (e_rd) begin
        m_tag = m_pc;
        m_pc = (m_pc + 1) % 16;
      end
      m_inflight = e_rd;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic add_row(input logic r, input logic rd, input logic v, input int pc, input int lvl);
    vec_t t;
    t.ready = r; t.exp_rd = rd; t.exp_valid = v; t.exp_pc = 4'(pc); t.exp_level = 2'(lvl);
    tbl.push_back(t);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"}, 32'(rom_rd_en), 32'd0);
    check({tag, "_valid"}, 32'(insn_valid), 32'd0);
    check({tag, "_data"}, insn_data, 32'd0);
    check({tag, "_pc"}, 32'(insn_pc), 32'd0);
    check({tag, "_level"}, 32'(fifo_level), 32'd0);
  endtask

  task automatic redirect_step(input int addr);
    redirect_valid = 1'b1;
    redirect_addr = 4'(addr);
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wrap_pcs [4];
    wrap_pcs = '{14, 15, 0, 1};

    // reset cycles 1..5 streaming, 10-cycle stall, release
    add_row(1, 1, 0, 0, 0);
    add_row(1, 1, 0, 0, 0);
    add_row(1, 1, 1, 0, 1);
    add_row(1, 1, 1, 1, 1);
    add_row(1, 1, 1, 2, 1);
    add_row(0, 0, 1, 3, 1);
    for (int i = 0; i < 9; i++) add_row(0, 0, 1, 3, 2);
    add_row(1, 1, 1, 3, 2);
    add_row(1, 1, 1, 4, 1);
    add_row(1, 1, 1, 5, 1);
    add_row(1, 1, 1, 6, 1);

    insn_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_outputs_zero("reset");
    NRES = 1'b1;
    model_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      insn_ready = tbl[i].ready;
      step();
      check($sformatf("tbl%0d_rd", i), 32'(s_rd), 32'(tbl[i].exp_rd));
      check($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].exp_valid));
      check($sformatf("tbl%0d_level", i), 32'(s_level), 32'(tbl[i].exp_level));
      if (tbl[i].exp_valid) begin
        check($sformatf("tbl%0d_pc", i), 32'(s_pc), 32'(tbl[i].exp_pc));
        check($sformatf("tbl%0d_data", i), s_data, 32'hF000_0000 + 32'(tbl[i].exp_pc));
      end
    end

    // mid-stream reset with a full FIFO
    insn_ready = 1'b0;
    step();
    step();
    check("pre_reset_level", 32'(s_level), 32'd2);
    #2 NRES = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    @(posedge CLK);
    @(posedge CLK);
    #1 NRES = 1'b1;
    model_reset();
    insn_ready = 1'b1;
    step();
    check("rst2_c1_rd", 32'(s_rd), 32'd1);
    check("rst2_c1_valid", 32'(s_valid), 32'd0);
    step();
    step();
    check("rst2_c3_valid", 32'(s_valid), 32'd1);
    check("rst2_c3_pc", 32'(s_pc), 32'd0);
    check("rst2_c3_data", s_data, 32'hF000_0000);

    // redirect to 5 while pc=2 is returning
    redirect_step(5);
    check("redir5_rd_low", 32'(s_rd), 32'd0);
    step();
    check("redir5_n1_valid", 32'(s_valid), 32'd0);
    check("redir5_n1_addr", 32'(s_addr), 32'd5);
    step();
    check("redir5_n2_valid", 32'(s_valid), 32'd0);
    step();
    check("redir5_n3_valid", 32'(s_valid), 32'd1);
    check("redir5_n3_pc", 32'(s_pc), 32'd5);

    // PC wrap
    redirect_step(14);
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("wrap%0d_valid", i), 32'(s_valid), 32'd1);
      check($sformatf("wrap%0d_pc", i), 32'(s_pc), 32'(wrap_pcs[i]));
    end

    // redirect coincident with the handshake of pc=3
    redirect_step(3);
    step();
    step();
    redirect_step(9);
    check("hs3_pc", 32'(s_pc), 32'd3);
    check("hs3_accept", 32'(s_accept), 32'd1);
    step();
    check("hs3_n1_valid", 32'(s_valid), 32'd0);
    step();
    check("hs3_n2_valid", 32'(s_valid), 32'd0);
    step();
    check("hs3_n3_pc", 32'(s_pc), 32'd9);

    // back-to-back redirects: the later one wins
    redirect_step(7);
    redirect_step(11);
    step();
    check("b2b_n1_valid", 32'(s_valid), 32'd0);
    step();
    check("b2b_n2_valid", 32'(s_valid), 32'd0);
    step();
    check("b2b_n3_valid", 32'(s_valid), 32'd1);
    check("b2b_n3_pc", 32'(s_pc), 32'd11);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      insn_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_addr  = 4'($urandom_range(0, 15));
      step();
    end
    redirect_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
